mem_access_stage: RTL and testbench

- Memory stage between the EX/MEM pipeline register and the MEM/WB register.
- Drives the data-memory request/ready handshake and stalls the pipeline while an access is outstanding.
- Formats load data (byte/half/word, signed/unsigned) and generates store byte enables.
- Resolves the PC-source select from branch/jump controls.

---
 rtl/mem_access_stage.sv | 190 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory request/ready handshake with stall and timeout,
// load formatting, store lane steering and PC-source resolution.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Branch_in,
    input  logic        zero_in,
    input  logic        jal_in,
    input  logic        jalr_in,
    input  logic        Mem_Read_in,
    input  logic        Mem_Write_in,
    input  logic        Mem_to_Reg_in,
    input  logic        Reg_Write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] RD_in,
    input  logic [31:0] ALU_Result_in,
    input  logic [31:0] muxb_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        pc_src,
    output logic        pc_jalr,
    output logic        wb_valid,
    output logic        wb_Reg_Write,
    output logic        wb_Mem_to_Reg,
    output logic [31:0] wb_RD,
    output logic [31:0] wb_ALU_Result,
    output logic [31:0] wb_mem_data,
    output logic        misalign_err,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    state_t          state_q;
    logic [TO_W-1:0] cnt_q;
    logic            req_q, we_q, busPend_q;
    logic [31:0]     addr_q, wdata_q, memData_q;
    logic [3:0]      be_q;
    logic [1:0]      lane_q;
    logic [2:0]      f3_q;
    logic            wbValid_q, wbRegWrite_q, wbMemToReg_q, misErr_q, busErr_q;
    logic [31:0]     wbRd_q, wbAlu_q, wbMemData_q;

    logic        memOp, misaligned;
    logic [1:0]  off;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, loadData_d, laneData;

    assign off        = ALU_Result_in[1:0];
    assign memOp      = Mem_Read_in | Mem_Write_in;
    assign misaligned = memOp & (((funct3_in[1:0] == 2'b01) & off[0]) |
                                 ((funct3_in[1:0] == 2'b10) & (off != 2'b00)));

    assign pc_src  = (Branch_in & zero_in) | jal_in | jalr_in;
    assign pc_jalr = jalr_in;
    assign stall   = (state_q == WAIT) | ((state_q == IDLE) & memOp & ~misaligned);

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = '0;
        if (Mem_Write_in) begin
            case (funct3_in[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << off;
                    wdata_d = {4{muxb_in[7:0]}};
                end
                2'b01: begin
                    be_d    = 4'b0011 << {off[1], 1'b0};
                    wdata_d = {2{muxb_in[15:0]}};
                end
                default: wdata_d = muxb_in;
            endcase
        end
    end

    // The byte/half lane is brought down to bit 0 before extension.
    assign laneData = dmem_rdata >> {lane_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  loadData_d = {{24{laneData[7]}}, laneData[7:0]};
            3'b001:  loadData_d = {{16{laneData[15]}}, laneData[15:0]};
            3'b100:  loadData_d = {24'b0, laneData[7:0]};
            3'b101:  loadData_d = {16'b0, laneData[15:0]};
            default: loadData_d = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            busPend_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            memData_q    <= '0;
            be_q         <= '0;
            lane_q       <= '0;
            f3_q         <= '0;
            wbValid_q    <= 1'b0;
            wbRegWrite_q <= 1'b0;
            wbMemToReg_q <= 1'b0;
            misErr_q     <= 1'b0;
            busErr_q     <= 1'b0;
            wbRd_q       <= '0;
            wbAlu_q      <= '0;
            wbMemData_q  <= '0;
        end else begin
            wbValid_q <= 1'b0;
            misErr_q  <= 1'b0;
            busErr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (memOp && !misaligned) begin
                        req_q     <= 1'b1;
                        we_q      <= Mem_Write_in;
                        addr_q    <= {ALU_Result_in[31:2], 2'b00};
                        be_q      <= be_d;
                        wdata_q   <= wdata_d;
                        lane_q    <= off;
                        f3_q      <= funct3_in;
                        cnt_q     <= '0;
                        busPend_q <= 1'b0;
                        state_q   <= WAIT;
                    end else begin
                        wbValid_q    <= 1'b1;
                        wbRegWrite_q <= Reg_Write_in & ~misaligned;
                        wbMemToReg_q <= Mem_to_Reg_in;
                        wbRd_q       <= RD_in;
                        wbAlu_q      <= ALU_Result_in;
                        wbMemData_q  <= '0;
                        misErr_q     <= misaligned;
                    end
                end
                WAIT: begin
                    // A ready arriving in the final timeout cycle still completes normally.
                    if (dmem_ready) begin
                        memData_q <= we_q ? 32'd0 : loadData_d;
                        req_q     <= 1'b0;
                        state_q   <= DONE;
                    end else if ((TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
                        memData_q <= '0;
                        busPend_q <= 1'b1;
                        req_q     <= 1'b0;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                DONE: begin
                    wbValid_q    <= 1'b1;
                    wbRegWrite_q <= Reg_Write_in & ~busPend_q;
                    wbMemToReg_q <= Mem_to_Reg_in;
                    wbRd_q       <= RD_in;
                    wbAlu_q      <= ALU_Result_in;
                    wbMemData_q  <= memData_q;
                    busErr_q     <= busPend_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_be       = be_q;
    assign dmem_wdata    = wdata_q;
    assign wb_valid      = wbValid_q;
    assign wb_Reg_Write  = wbRegWrite_q;
    assign wb_Mem_to_Reg = wbMemToReg_q;
    assign wb_RD         = wbRd_q;
    assign wb_ALU_Result = wbAlu_q;
    assign wb_mem_data   = wbMemData_q;
    assign misalign_err  = misErr_q;
    assign bus_err       = busErr_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset-in-WAIT sequence and
// random instructions checked against a per-instruction behavioural model.
module tb_mem_access_stage;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Branch_in = 0, zero_in = 0, jal_in = 0, jalr_in = 0;
    logic        Mem_Read_in = 0, Mem_Write_in = 0, Mem_to_Reg_in = 0, Reg_Write_in = 0;
    logic [2:0]  funct3_in = '0;
    logic [31:0] RD_in = '0, ALU_Result_in = '0, muxb_in = '0;
    logic        dmem_ready = 0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_req, dmem_we, stall, pc_src, pc_jalr;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_Reg_Write, wb_Mem_to_Reg, misalign_err, bus_err;
    logic [31:0] wb_RD, wb_ALU_Result, wb_mem_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
        .clk(clk), .rst(rst),
        .Branch_in(Branch_in), .zero_in(zero_in), .jal_in(jal_in), .jalr_in(jalr_in),
        .Mem_Read_in(Mem_Read_in), .Mem_Write_in(Mem_Write_in),
        .Mem_to_Reg_in(Mem_to_Reg_in), .Reg_Write_in(Reg_Write_in),
        .funct3_in(funct3_in), .RD_in(RD_in), .ALU_Result_in(ALU_Result_in), .muxb_in(muxb_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall(stall), .pc_src(pc_src), .pc_jalr(pc_jalr),
        .wb_valid(wb_valid), .wb_Reg_Write(wb_Reg_Write), .wb_Mem_to_Reg(wb_Mem_to_Reg),
        .wb_RD(wb_RD), .wb_ALU_Result(wb_ALU_Result), .wb_mem_data(wb_mem_data),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    typedef struct {
        logic br, zero, jal, jalr, memRead, memWrite, m2r, rw;
        logic [2:0]  f3;
        logic [31:0] rdIn, alu, muxb, rdata;
        int          delay;
        logic        expPcSrc, expWe, chkWdata, expRegWrite, expMis, expBus;
        logic [31:0] expAddr, expWdata, expMemData;
        logic [3:0]  expBe;
        int          expLat, expStall, expReq;
    } vec_t;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic memRead, input logic memWrite, input logic [2:0] f3,
                                   input logic [31:0] alu, input logic [31:0] muxb,
                                   input logic [31:0] rdata, input int delay);
        vec_t v;
        v = '{default: '0};
        v.memRead = memRead; v.memWrite = memWrite; v.f3 = f3;
        v.alu = alu; v.muxb = muxb; v.rdata = rdata; v.delay = delay;
        v.rw = !memWrite; v.m2r = memRead; v.rdIn = 32'd7;
        return v;
    endfunction

    function automatic vec_t withExp(input vec_t v, input logic pcSrc, input logic [31:0] addr,
                                     input logic we, input logic [3:0] be, input logic [31:0] wdata,
                                     input logic chkW, input logic [31:0] memData, input logic rw,
                                     input logic mis, input logic bus, input int lat,
                                     input int stl, input int req);
        vec_t r = v;
        r.expPcSrc = pcSrc; r.expAddr = addr; r.expWe = we; r.expBe = be; r.expWdata = wdata;
        r.chkWdata = chkW; r.expMemData = memData; r.expRegWrite = rw; r.expMis = mis;
        r.expBus = bus; r.expLat = lat; r.expStall = stl; r.expReq = req;
        return r;
    endfunction

    // Reference: what one instruction should produce, from the architectural rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int off, size, waitCycles;
        bit memOp, mis, timedOut;
        logic [31:0] lane;
        memOp = v.memRead || v.memWrite;
        off = int'(v.alu % 4);
        size = int'(v.f3 % 4);
        mis = memOp && ((size == 1 && off % 2 == 1) || (size == 2 && off != 0));
        r.expPcSrc = (v.br && v.zero) || v.jal || v.jalr;
        r.expAddr = '0; r.expWe = 0; r.expBe = '0; r.expWdata = '0; r.chkWdata = 0;
        r.expMemData = '0; r.expRegWrite = mis ? 1'b0 : v.rw; r.expMis = mis; r.expBus = 0;
        r.expLat = 1; r.expStall = 0; r.expReq = 0;
        if (memOp && !mis) begin
            timedOut = v.delay >= TIMEOUT;
            waitCycles = timedOut ? TIMEOUT : v.delay + 1;
            r.expLat = waitCycles + 2;
            r.expStall = waitCycles + 1;
            r.expReq = waitCycles;
            r.expAddr = v.alu - 32'(off);
            r.expWe = v.memWrite;
            if (v.memWrite) begin
                r.chkWdata = 1;
                if (size == 0) begin
                    r.expBe = 4'(1 << off);
                    r.expWdata = (v.muxb & 32'hFF) * 32'h0101_0101;
                end else if (size == 1) begin
                    r.expBe = 4'(3 << off);
                    r.expWdata = (v.muxb & 32'hFFFF) * 32'h0001_0001;
                end else begin
                    r.expBe = 4'hF;
                    r.expWdata = v.muxb;
                end
            end else begin
                r.expBe = 4'hF;
                lane = v.rdata >> (8 * off);
                if (!timedOut) begin
                    case (v.f3)
                        3'd0: r.expMemData = lane[7]  ? ((lane & 32'hFF) | 32'hFFFF_FF00) : (lane & 32'hFF);
                        3'd1: r.expMemData = lane[15] ? ((lane & 32'hFFFF) | 32'hFFFF_0000) : (lane & 32'hFFFF);
                        3'd4: r.expMemData = lane & 32'hFF;
                        3'd5: r.expMemData = lane & 32'hFFFF;
                        default: r.expMemData = v.rdata;
                    endcase
                end
            end
            if (timedOut) begin
                r.expRegWrite = 0;
                r.expBus = 1;
            end
        end
        return r;
    endfunction

    task automatic driveVec(input vec_t v);
        Branch_in = v.br; zero_in = v.zero; jal_in = v.jal; jalr_in = v.jalr;
        Mem_Read_in = v.memRead; Mem_Write_in = v.memWrite;
        Mem_to_Reg_in = v.m2r; Reg_Write_in = v.rw;
        funct3_in = v.f3; RD_in = v.rdIn; ALU_Result_in = v.alu; muxb_in = v.muxb;
    endtask

    task automatic checkOutput(input vec_t v, input int lat, input int stl, input int req);
        checkEq("latency", lat, v.expLat);
        checkEq("stall_cycles", stl, v.expStall);
        checkEq("req_cycles", req, v.expReq);
        checkEq("wb_RD", wb_RD, v.rdIn);
        checkEq("wb_ALU_Result", wb_ALU_Result, v.alu);
        checkEq("wb_Mem_to_Reg", wb_Mem_to_Reg, v.m2r);
        checkEq("wb_Reg_Write", wb_Reg_Write, v.expRegWrite);
        checkEq("wb_mem_data", wb_mem_data, v.expMemData);
        checkEq("misalign_err", misalign_err, v.expMis);
        checkEq("bus_err", bus_err, v.expBus);
    endtask

    // Called at posedge+1; holds the instruction until it retires, answering requests
    // after v.delay unanswered request cycles, with ready noise while no request is up.
    task automatic applyStimulus(input vec_t v);
        int cycles = 0, stl = 0, req = 0;
        bit done = 0;
        driveVec(v);
        while (!done && cycles < 40) begin
            if (dmem_req) begin
                dmem_ready = (req == v.delay);
                dmem_rdata = dmem_ready ? v.rdata : $urandom;
            end else begin
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
            #1;
            if (stall) stl++;
            checkEq("pc_src", pc_src, v.expPcSrc);
            checkEq("pc_jalr", pc_jalr, v.jalr);
            if (dmem_req) begin
                req++;
                checkEq("dmem_addr", dmem_addr, v.expAddr);
                checkEq("dmem_we", dmem_we, v.expWe);
                checkEq("dmem_be", dmem_be, v.expBe);
                if (v.chkWdata) checkEq("dmem_wdata", dmem_wdata, v.expWdata);
            end
            @(posedge clk); #1;
            cycles++;
            if (wb_valid) done = 1;
        end
        dmem_ready = 0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL wb_valid: no retirement after 40 cycles, expected latency %0d", v.expLat);
        end else begin
            checkOutput(v, cycles, stl, req);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;

        v = mkVec(0, 0, 3'b000, 32'h1234, 0, 0, 0); v.rdIn = 5; v.m2r = 0;
        tbl.push_back(withExp(v, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        v = mkVec(1, 0, 3'b000, 32'h103, 0, 32'h80FF_0000, 1);
        tbl.push_back(withExp(v, 0, 32'h100, 0, 4'hF, 0, 0, 32'hFFFF_FF80, 1, 0, 0, 4, 3, 2));
        v = mkVec(0, 1, 3'b001, 32'h22, 32'hAAAA_BEEF, 0, 0);
        tbl.push_back(withExp(v, 0, 32'h20, 1, 4'b1100, 32'hBEEF_BEEF, 1, 0, 0, 0, 0, 3, 2, 1));
        v = mkVec(1, 0, 3'b010, 32'h6, 0, 0, 0);
        tbl.push_back(withExp(v, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        v = mkVec(1, 0, 3'b010, 32'h40, 0, 32'h5555_5555, 99);
        tbl.push_back(withExp(v, 0, 32'h40, 0, 4'hF, 0, 0, 0, 0, 0, 1, 6, 5, 4));
        v = mkVec(0, 0, 3'b000, 32'h0, 0, 0, 0); v.br = 1; v.zero = 1;
        tbl.push_back(withExp(v, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        v = mkVec(1, 0, 3'b101, 32'h12, 0, 32'h8001_7FFF, 2);
        tbl.push_back(withExp(v, 0, 32'h10, 0, 4'hF, 0, 0, 32'h0000_8001, 1, 0, 0, 5, 4, 3));
        v = mkVec(1, 0, 3'b001, 32'h12, 0, 32'h8001_7FFF, 0);
        tbl.push_back(withExp(v, 0, 32'h10, 0, 4'hF, 0, 0, 32'hFFFF_8001, 1, 0, 0, 3, 2, 1));
        v = mkVec(0, 1, 3'b000, 32'h41, 32'h1234_5678, 0, 3);
        tbl.push_back(withExp(v, 0, 32'h40, 1, 4'b0010, 32'h7878_7878, 1, 0, 0, 0, 0, 6, 5, 4));
        v = mkVec(1, 0, 3'b100, 32'h101, 0, 32'h0000_F100, 0);
        tbl.push_back(withExp(v, 0, 32'h100, 0, 4'hF, 0, 0, 32'h0000_00F1, 1, 0, 0, 3, 2, 1));
        v = mkVec(1, 1, 3'b010, 32'h84, 32'hCAFE_F00D, 32'h1111_1111, 0);
        tbl.push_back(withExp(v, 0, 32'h84, 1, 4'hF, 32'hCAFE_F00D, 1, 0, 0, 0, 0, 3, 2, 1));
        v = mkVec(0, 0, 3'b000, 32'h9, 0, 0, 0); v.jalr = 1;
        tbl.push_back(withExp(v, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        v = mkVec(1, 0, 3'b011, 32'h8, 0, 32'h1234_ABCD, 1);
        tbl.push_back(withExp(v, 0, 32'h8, 0, 4'hF, 0, 0, 32'h1234_ABCD, 1, 0, 0, 4, 3, 2));
        v = mkVec(1, 0, 3'b001, 32'h11, 0, 0, 0);
        tbl.push_back(withExp(v, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        v = mkVec(0, 1, 3'b010, 32'h3, 32'hDEAD_BEEF, 0, 0);
        tbl.push_back(withExp(v, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        checkEq("reset dmem_req", dmem_req, 0);
        checkEq("reset dmem_we", dmem_we, 0);
        checkEq("reset dmem_addr", dmem_addr, 0);
        checkEq("reset dmem_be", dmem_be, 0);
        checkEq("reset dmem_wdata", dmem_wdata, 0);
        checkEq("reset wb_valid", wb_valid, 0);
        checkEq("reset wb_Reg_Write", wb_Reg_Write, 0);
        checkEq("reset wb_RD", wb_RD, 0);
        checkEq("reset wb_ALU_Result", wb_ALU_Result, 0);
        checkEq("reset wb_mem_data", wb_mem_data, 0);
        checkEq("reset misalign_err", misalign_err, 0);
        checkEq("reset bus_err", bus_err, 0);
        checkEq("reset stall", stall, 0);
        rst = 0;

        for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

        // Reset while a load waits: request drops, nothing retires, stage is idle again.
        v = mkVec(1, 0, 3'b010, 32'h200, 0, 0, 0);
        driveVec(v);
        dmem_ready = 0;
        @(posedge clk); #1;
        checkEq("rstseq dmem_req before", dmem_req, 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        Mem_Read_in = 0;
        #1;
        checkEq("rstseq dmem_req", dmem_req, 0);
        checkEq("rstseq wb_valid", wb_valid, 0);
        checkEq("rstseq stall", stall, 0);
        @(posedge clk); #1;
        checkEq("rstseq idle retire", wb_valid, 1);
        checkEq("rstseq wb_ALU_Result", wb_ALU_Result, 32'h200);

        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            v = mkVec(kind == 1 || kind == 3, kind >= 2, 3'd0, $urandom, $urandom, $urandom,
                      $urandom_range(0, 5));
            v.f3 = v.memWrite ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            v.rdIn = $urandom_range(0, 31);
            v.rw = 1'($urandom_range(0, 1));
            v.m2r = 1'($urandom_range(0, 1));
            v.br = 1'($urandom_range(0, 1));
            v.zero = 1'($urandom_range(0, 1));
            v.jal = ($urandom_range(0, 7) == 0);
            v.jalr = ($urandom_range(0, 7) == 0);
            applyStimulus(model(v));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
